// File: rtl/c499_pkg.sv
// Shared types and constants for the c499 byte-serial frame front end.
// Also maps assembled vector bits onto the corrector's N-numbered inputs.
package c499_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } state_t;

    localparam int FRAME_BYTES = 5;
    localparam int DATA_W      = 32;
    localparam int CHK_W       = 8;

    // Data bit i lands on corrector input N(1+4i); check bit j on N(129+j).
    function automatic int data_n_index(input int bit_i);
        return 1 + 4 * bit_i;
    endfunction

    function automatic int check_n_index(input int bit_j);
        return 129 + bit_j;
    endfunction

endpackage

// File: rtl/c499_gap_timer.sv
// Inter-byte gap counter: cleared by a beat or while not running,
// flags expiry once LIMIT idle cycles have accumulated.
module c499_gap_timer #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clr,
    output logic expire
);

    localparam int TW = $clog2(LIMIT + 1);

    logic [TW-1:0] tmo;

    assign expire = run && (tmo == TW'(LIMIT));

    always_ff @(posedge clk) begin
        if (rst || clr || !run)
            tmo <= '0;
        else if (!expire)
            tmo <= tmo + TW'(1);
    end

endmodule

// File: rtl/c499_frame_assembler.sv
// Collects four data bytes plus one check byte into the 41-bit c499 input
// vector and holds it behind a valid/ready handshake.
module c499_frame_assembler
    import c499_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_data,
    input  logic              in_sof,
    input  logic              cfg_en,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CHK_W-1:0]  out_check,
    output logic              out_en,
    output logic              err_frame,
    output logic [CNT_W-1:0]  frame_cnt
);

    localparam int LANES = DATA_W / 8;

    state_t                 state, state_nxt;
    logic [2:0]             idx;
    logic                   beat, expire, run, err_nxt, chk_we;
    logic [LANES-1:0]       lane_we;
    logic [LANES-1:0][7:0]  data_q;

    assign in_ready  = (state != HOLD);
    assign out_valid = (state == HOLD);
    assign beat      = in_valid && in_ready;
    assign run       = (state == COLLECT);
    assign out_data  = data_q;

    c499_gap_timer #(.LIMIT(TIMEOUT)) u_gap (
        .clk    (clk),
        .rst    (rst),
        .run    (run),
        .clr    (beat),
        .expire (expire)
    );

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (beat && in_sof) state_nxt = COLLECT;
            COLLECT: begin
                if (beat) begin
                    if (!in_sof && idx == 3'(FRAME_BYTES - 1)) state_nxt = HOLD;
                end else if (expire) begin
                    state_nxt = IDLE;
                end
            end
            HOLD:    if (out_ready) state_nxt = HOLD == HOLD ? IDLE : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A sof beat always restarts the frame, even in place of the check byte.
    always_comb begin
        lane_we = '0;
        chk_we  = 1'b0;
        err_nxt = 1'b0;
        case (state)
            IDLE: begin
                lane_we[0] = beat && in_sof;
                err_nxt    = beat && !in_sof;
            end
            COLLECT: begin
                if (beat) begin
                    if (in_sof) begin
                        lane_we[0] = 1'b1;
                        err_nxt    = 1'b1;
                    end else if (idx == 3'(FRAME_BYTES - 1)) begin
                        chk_we = 1'b1;
                    end else begin
                        lane_we[idx[1:0]] = 1'b1;
                    end
                end else begin
                    err_nxt = expire;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx       <= '0;
            data_q    <= '0;
            out_check <= '0;
            out_en    <= 1'b0;
            err_frame <= 1'b0;
        end else begin
            err_frame <= err_nxt;
            if (lane_we[0])
                idx <= 3'd1;
            else if (|lane_we[LANES-1:1])
                idx <= idx + 3'd1;
            else if (state_nxt != COLLECT)
                idx <= '0;
            for (int i = 0; i < LANES; i++)
                if (lane_we[i]) data_q[i] <= in_data;
            if (lane_we[0]) out_en <= cfg_en;
            if (chk_we) out_check <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            frame_cnt <= '0;
        else if (state == HOLD && out_ready && frame_cnt != '1)
            frame_cnt <= frame_cnt + CNT_W'(1);
    end

endmodule

// File: tb/tb_c499_frame_assembler.sv
// Directed bench for the c499 frame assembler (TIMEOUT=4, CNT_W=2).
module tb_c499_frame_assembler;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_sof, cfg_en;
    logic [7:0]  in_data;
    logic        out_valid, out_ready, out_en, err_frame;
    logic [31:0] out_data;
    logic [7:0]  out_check;
    logic [1:0]  frame_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    c499_frame_assembler #(.TIMEOUT(4), .CNT_W(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sof    (in_sof),
        .cfg_en    (cfg_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_check (out_check),
        .out_en    (out_en),
        .err_frame (err_frame),
        .frame_cnt (frame_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic sof);
        in_valid = 1'b1;
        in_data  = d;
        in_sof   = sof;
        tick();
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic frame(input logic [7:0] b0, b1, b2, b3, c);
        send(b0, 1'b1);
        send(b1, 1'b0);
        send(b2, 1'b0);
        send(b3, 1'b0);
        send(c,  1'b0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_data = '0;
        cfg_en = 1'b0; out_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_data",  out_data, 32'h0);
        chk("rst_check", 32'(out_check), 32'h0);
        chk("rst_en",    32'(out_en), 32'h0);
        chk("rst_err",   32'(err_frame), 32'h0);
        chk("rst_cnt",   32'(frame_cnt), 32'h0);
        chk("rst_ready", 32'(in_ready), 32'h1);

        // basic frame, cfg_en only sampled on byte 0
        out_ready = 1'b1;
        cfg_en = 1'b1;
        send(8'h11, 1'b1);
        cfg_en = 1'b0;
        send(8'h22, 1'b0); send(8'h33, 1'b0); send(8'h44, 1'b0); send(8'hA5, 1'b0);
        chk("f1_valid", 32'(out_valid), 32'h1);
        chk("f1_ready", 32'(in_ready), 32'h0);
        chk("f1_data",  out_data, 32'h44332211);
        chk("f1_check", 32'(out_check), 32'hA5);
        chk("f1_en",    32'(out_en), 32'h1);
        chk("f1_err",   32'(err_frame), 32'h0);
        tick();
        chk("f1_ready_back", 32'(in_ready), 32'h1);
        chk("f1_valid_drop", 32'(out_valid), 32'h0);
        chk("f1_cnt",        32'(frame_cnt), 32'h1);

        // held output with back-pressure; stray sof beats must be ignored
        out_ready = 1'b0;
        frame(8'h11, 8'h22, 8'h33, 8'h44, 8'hA5);
        chk("f2_en", 32'(out_en), 32'h0);
        in_valid = 1'b1; in_sof = 1'b1; in_data = 8'hEE;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("f2_hold_valid", 32'(out_valid), 32'h1);
            chk("f2_hold_ready", 32'(in_ready), 32'h0);
            chk("f2_hold_data",  out_data, 32'h44332211);
            chk("f2_hold_check", 32'(out_check), 32'hA5);
            chk("f2_hold_err",   32'(err_frame), 32'h0);
        end
        in_valid = 1'b0; in_sof = 1'b0;
        chk("f2_cnt_hold", 32'(frame_cnt), 32'h1);
        out_ready = 1'b1;
        tick();
        chk("f2_idle_valid", 32'(out_valid), 32'h0);
        chk("f2_idle_ready", 32'(in_ready), 32'h1);
        chk("f2_cnt",        32'(frame_cnt), 32'h2);

        // stray byte in IDLE, then a clean frame
        send(8'hFF, 1'b0);
        chk("f3_stray_err", 32'(err_frame), 32'h1);
        chk("f3_stray_vld", 32'(out_valid), 32'h0);
        tick();
        chk("f3_err_clear", 32'(err_frame), 32'h0);
        frame(8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h3C);
        chk("f3_data",  out_data, 32'hDDCCBBAA);
        chk("f3_check", 32'(out_check), 32'h3C);
        chk("f3_err",   32'(err_frame), 32'h0);
        tick();
        chk("f3_cnt", 32'(frame_cnt), 32'h3);

        // sof mid-frame aborts and restarts
        send(8'h77, 1'b1);
        send(8'h88, 1'b0);
        send(8'h01, 1'b1);
        chk("f4_abort_err", 32'(err_frame), 32'h1);
        send(8'h02, 1'b0);
        chk("f4_err_clear", 32'(err_frame), 32'h0);
        send(8'h03, 1'b0); send(8'h04, 1'b0); send(8'h05, 1'b0);
        chk("f4_valid", 32'(out_valid), 32'h1);
        chk("f4_data",  out_data, 32'h04030201);
        chk("f4_check", 32'(out_check), 32'h05);
        tick();
        chk("f4_cnt_sat", 32'(frame_cnt), 32'h3);

        // timeout: error exactly TIMEOUT+1 cycles after the last beat
        send(8'h10, 1'b1);
        chk("t_beat_err", 32'(err_frame), 32'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t_wait_err", 32'(err_frame), 32'h0);
        end
        tick();
        chk("t_expire_err", 32'(err_frame), 32'h1);
        send(8'h20, 1'b0);
        chk("t_idle_drop", 32'(err_frame), 32'h1);
        tick();
        chk("t_err_clear", 32'(err_frame), 32'h0);

        // beat arriving on the expiry cycle wins
        send(8'h61, 1'b1);
        for (int i = 0; i < 4; i++) tick();
        send(8'h62, 1'b0);
        chk("t_late_beat_err", 32'(err_frame), 32'h0);
        send(8'h63, 1'b0); send(8'h64, 1'b0); send(8'h65, 1'b0);
        chk("t_late_valid", 32'(out_valid), 32'h1);
        chk("t_late_data",  out_data, 32'h64636261);
        chk("t_late_check", 32'(out_check), 32'h65);
        tick();
        chk("t_late_cnt", 32'(frame_cnt), 32'h3);

        // reset mid-frame
        cfg_en = 1'b1;
        send(8'h99, 1'b1);
        send(8'h98, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("r_valid", 32'(out_valid), 32'h0);
        chk("r_data",  out_data, 32'h0);
        chk("r_check", 32'(out_check), 32'h0);
        chk("r_en",    32'(out_en), 32'h0);
        chk("r_err",   32'(err_frame), 32'h0);
        chk("r_cnt",   32'(frame_cnt), 32'h0);
        chk("r_ready", 32'(in_ready), 32'h1);
        tick();
        chk("r_err_after", 32'(err_frame), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
